// File: rtl/uart_tx_fifo_feeder_if.sv
// Handshake bundle between a byte producer (e.g. UART RX) and the TX feeder.
// The producer or bench uses the master modport; the feeder uses the slave modport.
interface uart_tx_fifo_feeder_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic            wr_stb;
    logic [DBIT-1:0] wr_data;
    logic            tx_done_tick;
    logic            clr_ovf;
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            ovf_pulse;
    logic            ovf_flag;

    modport master (
        output wr_stb, wr_data, tx_done_tick, clr_ovf,
        input  tx_start, tx_din, empty, full, count, ovf_pulse, ovf_flag
    );
    modport slave (
        input  wr_stb, wr_data, tx_done_tick, clr_ovf,
        output tx_start, tx_din, empty, full, count, ovf_pulse, ovf_flag
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus a one-outstanding-byte scheduler feeding a UART transmitter.
// Pops are decided from the registered empty, so a write never pops on its own edge.
module uart_tx_fifo_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    uart_tx_fifo_feeder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              pop, push, ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.empty) state_nxt = BUSY;
            BUSY:    if (bus.tx_done_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = (state == IDLE) && !bus.empty;
    end

    // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
    assign push      = bus.wr_stb && (!bus.full || pop);
    assign ovf       = bus.wr_stb && bus.full && !pop;
    assign count_nxt = bus.count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            bus.count     <= '0;
            bus.empty     <= 1'b1;
            bus.full      <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.tx_din    <= '0;
            bus.ovf_pulse <= 1'b0;
            bus.ovf_flag  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                bus.tx_din <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            bus.tx_start  <= pop;
            bus.count     <= count_nxt;
            bus.empty     <= (count_nxt == '0);
            bus.full      <= (count_nxt == FULL_CNT);
            bus.ovf_pulse <= ovf;
            // A new overflow wins over a same-edge clear.
            if (ovf)              bus.ovf_flag <= 1'b1;
            else if (bus.clr_ovf) bus.ovf_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a tx_start monitor and a scripted transmitter.
module tb_uart_tx_fifo_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] got[$];

    uart_tx_fifo_feeder_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_tx_fifo_feeder #(.DBIT(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every byte handed to the transmitter.
    always @(posedge clk) begin
        #1;
        if (!rst && bus.tx_start) got.push_back(bus.tx_din);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transmitter stand-in: wait for byte k, stay busy gap cycles, then return done.
    task automatic xmit(input int k, input int gap);
        int t = 0;
        while (got.size() <= k && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (got.size() <= k) begin
            chk("start_timeout", 32'(got.size()), 32'(k + 1));
            return;
        end
        repeat (gap) @(negedge clk);
        chk("one_outstanding", 32'(got.size()), 32'(k + 1));
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.wr_stb = 0; bus.wr_data = '0; bus.tx_done_tick = 0; bus.clr_ovf = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_din", bus.tx_din, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", {bus.ovf_pulse, bus.ovf_flag}, 0);

        // 1: single byte latency
        bus.wr_stb = 1; bus.wr_data = 8'hA5;
        @(negedge clk);
        bus.wr_stb = 0;
        chk("t1_count1", bus.count, 1);
        chk("t1_empty0", bus.empty, 0);
        chk("t1_no_start_yet", bus.tx_start, 0);
        @(negedge clk);
        chk("t1_start", bus.tx_start, 1);
        chk("t1_din", bus.tx_din, 8'hA5);
        chk("t1_count0", bus.count, 0);
        chk("t1_empty1", bus.empty, 1);
        @(negedge clk);
        chk("t1_start_low", bus.tx_start, 0);
        bus.tx_done_tick = 1;
        @(negedge clk);
        bus.tx_done_tick = 0;
        repeat (3) @(negedge clk);
        chk("t1_one_start", 32'(got.size()), 1);

        // 2: three back-to-back writes, slow transmitter
        got.delete();
        for (int i = 1; i <= 3; i++) begin
            bus.wr_stb = 1; bus.wr_data = 8'(i * 8'h11);
            @(negedge clk);
        end
        bus.wr_stb = 0;
        for (int k = 0; k < 3; k++) xmit(k, 50);
        repeat (5) @(negedge clk);
        chk("t2_n", 32'(got.size()), 3);
        chk("t2_b0", got[0], 8'h11);
        chk("t2_b1", got[1], 8'h22);
        chk("t2_b2", got[2], 8'h33);
        chk("t2_empty", bus.empty, 1);

        // 3: fill while the transmitter is held busy, then overflow
        got.delete();
        for (int i = 0; i < 17; i++) begin
            bus.wr_stb = 1; bus.wr_data = 8'(i);
            @(negedge clk);
        end
        bus.wr_stb = 0;
        chk("t3_count16", bus.count, 16);
        chk("t3_full", bus.full, 1);
        chk("t3_no_ovf", bus.ovf_flag, 0);
        chk("t3_in_flight", 32'(got.size()), 1);
        chk("t3_first", got[0], 8'h00);
        bus.wr_stb = 1; bus.wr_data = 8'h11;
        @(negedge clk);
        bus.wr_stb = 0;
        chk("t3_ovf_pulse", bus.ovf_pulse, 1);
        chk("t3_ovf_flag", bus.ovf_flag, 1);
        chk("t3_count_held", bus.count, 16);
        @(negedge clk);
        chk("t3_pulse_1cyc", bus.ovf_pulse, 0);
        chk("t3_flag_sticky", bus.ovf_flag, 1);
        bus.clr_ovf = 1;
        @(negedge clk);
        bus.clr_ovf = 0;
        chk("t3_flag_clr", bus.ovf_flag, 0);
        bus.wr_stb = 1; bus.wr_data = 8'h12; bus.clr_ovf = 1;
        @(negedge clk);
        bus.wr_stb = 0; bus.clr_ovf = 0;
        chk("t3_ovf_beats_clr", bus.ovf_flag, 1);
        bus.clr_ovf = 1;
        @(negedge clk);
        bus.clr_ovf = 0;
        chk("t3_flag_clr2", bus.ovf_flag, 0);

        // 4: write on the pop edge of a full FIFO
        bus.tx_done_tick = 1;
        @(negedge clk);
        bus.tx_done_tick = 0;
        bus.wr_stb = 1; bus.wr_data = 8'h77;
        @(negedge clk);
        bus.wr_stb = 0;
        chk("t4_count16", bus.count, 16);
        chk("t4_no_ovf", bus.ovf_pulse, 0);
        chk("t4_start", bus.tx_start, 1);
        chk("t4_pop", bus.tx_din, 8'h01);
        for (int k = 1; k < 18; k++) xmit(k, 3);
        repeat (5) @(negedge clk);
        chk("t4_n", 32'(got.size()), 18);
        for (int k = 1; k < 17; k++) chk("t4_order", got[k], 32'(k));
        chk("t4_last", got[17], 8'h77);
        chk("t4_empty", bus.empty, 1);
        chk("t4_count0", bus.count, 0);

        // 5: pointer wrap over 40 bytes
        got.delete();
        fork
            for (int i = 0; i < 40; i++) begin
                bus.wr_stb = 1; bus.wr_data = 8'(i);
                @(negedge clk);
                bus.wr_stb = 0;
                repeat (20) @(negedge clk);
            end
            for (int k = 0; k < 40; k++) xmit(k, 20);
        join
        repeat (5) @(negedge clk);
        chk("t5_n", 32'(got.size()), 40);
        for (int k = 0; k < 40; k++) chk("t5_order", got[k], 32'(k));
        chk("t5_count0", bus.count, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_no_ovf", bus.ovf_flag, 0);

        // 6: asynchronous reset while busy
        got.delete();
        for (int i = 0; i < 6; i++) begin
            bus.wr_stb = 1; bus.wr_data = 8'(8'hC0 + i);
            @(negedge clk);
        end
        bus.wr_stb = 0;
        chk("t6_count5", bus.count, 5);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", bus.count, 0);
        chk("t6_async_empty", bus.empty, 1);
        chk("t6_async_din", bus.tx_din, 0);
        chk("t6_async_start", bus.tx_start, 0);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        repeat (10) @(negedge clk);
        chk("t6_quiet", 32'(got.size()), 0);
        bus.wr_stb = 1; bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_stb = 0;
        xmit(0, 5);
        chk("t6_new_byte", got[0], 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
